// File: rtl/reflet_irq_conditioner.sv
// Reflet interrupt line conditioner: two-flop synchronizer, optional glitch filter and
// per-line level / rising-edge selection. Define REFLET_IRQ_DEBOUNCE_EN to build the filter.
module reflet_irq_conditioner #(
  parameter int unsigned debounce_cycles = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] irq_in,
  input  logic [3:0] mode,
  input  logic [3:0] ack,
  output logic [3:0] interrupt_request,
  output logic [3:0] pending
);
  localparam logic [7:0] CNT_LAST = 8'(debounce_cycles - 32'd1);

  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] filt_prev_q, filt_prev_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] filt_s;
  logic [3:0] rise_s;

`ifdef REFLET_IRQ_DEBOUNCE_EN
  logic [3:0] filt_q, filt_d;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  // Debounce: accept a new level only after D consecutive disagreeing cycles
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (enable) begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end else begin
      filt_d = filt_q;
    end
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_q <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_s = filt_q;
`else
  logic unused_debounce_s;
  assign unused_debounce_s = ^CNT_LAST;
  assign filt_s = sync2_q;
`endif

  // Synchronizer, edge detect and pending latch; a rise beats a same-cycle ack
  always_comb begin
    rise_s = filt_s & ~filt_prev_q;
    if (enable) begin
      sync1_d     = irq_in;
      sync2_d     = sync1_q;
      filt_prev_d = filt_s;
      pend_d      = mode & (rise_s | (pend_q & ~ack));
    end else begin
      sync1_d     = sync1_q;
      sync2_d     = sync2_q;
      filt_prev_d = filt_prev_q;
      pend_d      = pend_q;
    end
  end

  // Line state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 4'h0;
      sync2_q     <= 4'h0;
      filt_prev_q <= 4'h0;
      pend_q      <= 4'h0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_prev_q <= filt_prev_d;
      pend_q      <= pend_d;
    end
  end

  assign interrupt_request = (mode & pend_q) | (~mode & filt_s);
  assign pending           = pend_q;
endmodule
